// File: rtl/mmap_apb_bridge.sv
// mmap_apb_bridge: converts the SoC memory-mapped peripheral request
// (picorv32-style valid/ready) into APB3 SETUP/ACCESS transfers.
// It decodes the slave index from the address, muxes read data back, and
// reports slave errors and decode misses on err_o.
//
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that run
// for TIMEOUT_CYC cycles without pready. An aborted transfer returns
// 32'hDEAD_BEEF with err_o set. The default build (macro undefined) waits
// for pready indefinitely.
//
// Handshake: the requester raises mmap_valid_i and holds
// addr/wdata/wstrb stable until it sees mmap_ready_o=1. mmap_ready_o is a
// single-cycle pulse, and mmap_rdata_o/err_o are meaningful only in that
// cycle. The requester drops valid in the cycle after ready. On the APB
// side a transfer is SETUP (psel=1, penable=0) for one cycle, then ACCESS
// (psel=1, penable=1) until the selected slave returns pready=1.
//
// dbg_state_o exposes the FSM state: 0=IDLE 1=SETUP 2=ACCESS 3=RESP.
module mmap_apb_bridge #(
  parameter int NUM_SLV     = 8,
  parameter int SLV_SEL_LSB = 12,
  parameter int APB_AW      = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mmap_valid_i,
  input  logic [31:0]            mmap_addr_i,
  input  logic [31:0]            mmap_wdata_i,
  input  logic [3:0]             mmap_wstrb_i,
  output logic [31:0]            mmap_rdata_o,
  output logic                   mmap_ready_o,
  output logic [APB_AW-1:0]      paddr_o,
  output logic [31:0]            pwdata_o,
  output logic [3:0]             pstrb_o,
  output logic                   pwrite_o,
  output logic [NUM_SLV-1:0]     psel_o,
  output logic                   penable_o,
  input  logic [32*NUM_SLV-1:0]  prdata_i,
  input  logic [NUM_SLV-1:0]     pready_i,
  input  logic [NUM_SLV-1:0]     pslverr_i,
  output logic                   err_o,
  output logic [1:0]             dbg_state_o
);

  // The index field is one bit wider than the slave count strictly needs.
  // With a power-of-two NUM_SLV this still lets an address with an
  // out-of-range index (for example 9 with 8 slaves) register as a decode
  // miss instead of aliasing onto a real slave.
  localparam int SEL_W = $clog2(NUM_SLV + 1);
  localparam logic [SEL_W-1:0] NUM_SLV_W = SEL_W'(NUM_SLV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [APB_AW-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [SEL_W-1:0]    idx_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [SEL_W-1:0]    idx_in;
  logic                hit_in;
  logic                sel_pready;
  logic                sel_pslverr;
  logic [31:0]         sel_prdata;
  logic                timeout_hit;
  logic                active;

  // Only the low APB_AW bits and the index field of the address are used.
  logic unused_addr;
  assign unused_addr = ^mmap_addr_i;

  assign idx_in = mmap_addr_i[SLV_SEL_LSB +: SEL_W];
  assign hit_in = (idx_in < NUM_SLV_W);

  // Mux the selected slave's response. The other slaves are ignored.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = 32'h0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx_q == SEL_W'(k)) begin
        sel_pready  = pready_i[k];
        sel_pslverr = pslverr_i[k];
        sel_prdata  = prdata_i[32*k +: 32];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] cnt_q;

  // The ACCESS wait counter clears on entry to ACCESS and counts cycles
  // without pready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'h0;
    end else if (state_q == SETUP) begin
      cnt_q <= 16'h0;
    end else if (state_q == ACCESS && !sel_pready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Abort on the cycle whose increment would reach the limit. A limit of
  // 4 therefore allows exactly 4 ACCESS cycles.
  assign timeout_hit = !sel_pready && (cnt_q == TO_LIM - 16'd1);
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mmap_valid_i) begin
          state_d = hit_in ? SETUP : RESP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (sel_pready || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches and the captured response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mmap_valid_i) begin
            addr_q  <= mmap_addr_i[APB_AW-1:0];
            wdata_q <= mmap_wdata_i;
            wstrb_q <= mmap_wstrb_i;
            idx_q   <= idx_in;
            rdata_q <= 32'h0;
            err_q   <= !hit_in;
          end
        end
        ACCESS: begin
          if (sel_pready) begin
            rdata_q <= (sel_pslverr || (|wstrb_q)) ? 32'h0 : sel_prdata;
            err_q   <= sel_pslverr;
          end else if (timeout_hit) begin
            rdata_q <= 32'hDEAD_BEEF;
            err_q   <= 1'b1;
          end
        end
        RESP: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign active = (state_q == SETUP) || (state_q == ACCESS);

  // APB and mmap outputs decode directly from the state and the latches.
  // The APB request fields read as zero outside SETUP/ACCESS.
  always_comb begin
    paddr_o      = active ? addr_q : '0;
    pwdata_o     = active ? wdata_q : 32'h0;
    pstrb_o      = active ? wstrb_q : 4'h0;
    pwrite_o     = active && (|wstrb_q);
    penable_o    = (state_q == ACCESS);
    mmap_ready_o = (state_q == RESP);
    mmap_rdata_o = (state_q == RESP) ? rdata_q : 32'h0;
    err_o        = (state_q == RESP) && err_q;
    dbg_state_o  = state_q;
    psel_o       = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      psel_o[k] = active && (idx_q == SEL_W'(k));
    end
  end

endmodule

// File: tb/tb_mmap_apb_bridge.sv
// Directed testbench for mmap_apb_bridge. It acts as the requester and as
// the APB slaves, and checks latency, select, APB fields, read data and
// error pulses against hand-computed values.
module tb_mmap_apb_bridge;

  localparam int NUM_SLV = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mmap_valid;
  logic [31:0]           mmap_addr;
  logic [31:0]           mmap_wdata;
  logic [3:0]            mmap_wstrb;
  logic [31:0]           mmap_rdata;
  logic                  mmap_ready;
  logic [11:0]           paddr;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic                  pwrite;
  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic [32*NUM_SLV-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;
  logic                  err;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;

  // Results of the last transfer.
  bit          r_done;
  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_err_cnt;
  int          r_sel_cyc;
  logic [7:0]  r_psel_or;
  bit          r_bad_sel;
  bit          r_unstable;
  logic [11:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic        r_pwrite;

  mmap_apb_bridge #(
    .NUM_SLV(NUM_SLV), .SLV_SEL_LSB(12), .APB_AW(12), .TIMEOUT_CYC(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mmap_valid_i(mmap_valid), .mmap_addr_i(mmap_addr),
    .mmap_wdata_i(mmap_wdata), .mmap_wstrb_i(mmap_wstrb),
    .mmap_rdata_o(mmap_rdata), .mmap_ready_o(mmap_ready),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .err_o(err), .dbg_state_o(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and play the APB slaves. The selected slave answers
  // pready on ACCESS cycle waits+1. r_lat counts posedges from the one that
  // samples valid up to the one after which mmap_ready is seen.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int waits, input int slv,
                      input logic [31:0] slv_rdata, input bit slverr,
                      input bit others_rdy, input int budget);
    logic [NUM_SLV-1:0] exp_sel;
    int acc;
    exp_sel = '0;
    if (slv < NUM_SLV) exp_sel[slv] = 1'b1;
    acc = 0;
    r_done = 0; r_lat = 0; r_rdata = 'x; r_err = 'x; r_err_cnt = 0;
    r_sel_cyc = 0; r_psel_or = '0; r_bad_sel = 0; r_unstable = 0;
    r_paddr = '0; r_pwdata = '0; r_pstrb = '0; r_pwrite = 1'b0;
    @(negedge clk);
    mmap_valid = 1'b1;
    mmap_addr  = addr;
    mmap_wdata = wdata;
    mmap_wstrb = wstrb;
    for (int k = 0; k < NUM_SLV; k++) prdata[32*k +: 32] = 32'hEE00_0000 | k;
    if (slv < NUM_SLV) prdata[32*slv +: 32] = slv_rdata;
    pslverr = slverr ? '1 : ~exp_sel;
    pready  = others_rdy ? ~exp_sel : '0;
    for (int i = 0; i < budget && !r_done; i++) begin
      @(posedge clk);
      r_lat++;
      @(negedge clk);
      if (psel != '0) begin
        if (r_sel_cyc == 0) begin
          r_paddr = paddr; r_pwdata = pwdata; r_pstrb = pstrb; r_pwrite = pwrite;
        end else if (paddr !== r_paddr || pwdata !== r_pwdata ||
                     pstrb !== r_pstrb || pwrite !== r_pwrite) begin
          r_unstable = 1;
        end
        r_sel_cyc++;
        r_psel_or = r_psel_or | psel;
        if (psel !== exp_sel) r_bad_sel = 1;
      end
      if (err) r_err_cnt++;
      if (penable && psel != '0) begin
        acc++;
        if (slv < NUM_SLV) pready[slv] = (acc > waits);
      end else if (slv < NUM_SLV) begin
        pready[slv] = 1'b0;
      end
      if (mmap_ready) begin
        r_done  = 1;
        r_rdata = mmap_rdata;
        r_err   = err;
      end
    end
    mmap_valid = 1'b0;
    pready     = '0;
    pslverr    = '0;
  endtask

  initial begin
    rst = 1'b1; mmap_valid = 1'b0; mmap_addr = '0; mmap_wdata = '0;
    mmap_wstrb = '0; prdata = '0; pready = '0; pslverr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_ready", mmap_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rdata", mmap_rdata, 0);
    chk("rst_state", dbg_state, 0);

    // Read slave 2 with zero wait states.
    xfer(32'h0000_2034, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 0, 0, 50);
    chk("rd2_done", r_done, 1);
    chk("rd2_lat", r_lat, 3);
    chk("rd2_sel_cyc", r_sel_cyc, 2);
    chk("rd2_psel", r_psel_or, 8'b0000_0100);
    chk("rd2_bad_sel", r_bad_sel, 0);
    chk("rd2_paddr", r_paddr, 12'h034);
    chk("rd2_pwrite", r_pwrite, 0);
    chk("rd2_rdata", r_rdata, 32'h1234_5678);
    chk("rd2_err", r_err_cnt, 0);
    @(negedge clk);
    chk("rd2_idle_ready", mmap_ready, 0);
    chk("rd2_idle_paddr", paddr, 0);
    chk("rd2_idle_state", dbg_state, 0);

    // Write to slave 0 with two wait states. The slave's prdata is ignored.
    xfer(32'h0000_0010, 32'hA5A5_0F0F, 4'h3, 2, 0, 32'hDDDD_DDDD, 0, 0, 50);
    chk("wr0_done", r_done, 1);
    chk("wr0_lat", r_lat, 5);
    chk("wr0_sel_cyc", r_sel_cyc, 4);
    chk("wr0_psel", r_psel_or, 8'b0000_0001);
    chk("wr0_pwrite", r_pwrite, 1);
    chk("wr0_pstrb", r_pstrb, 4'h3);
    chk("wr0_pwdata", r_pwdata, 32'hA5A5_0F0F);
    chk("wr0_paddr", r_paddr, 12'h010);
    chk("wr0_stable", r_unstable, 0);
    chk("wr0_rdata", r_rdata, 32'h0);
    chk("wr0_err", r_err_cnt, 0);

    // Read slave 1 while it reports pslverr.
    xfer(32'h0000_1008, 32'h0, 4'h0, 0, 1, 32'hFFFF_FFFF, 1, 0, 50);
    chk("err1_done", r_done, 1);
    chk("err1_lat", r_lat, 3);
    chk("err1_psel", r_psel_or, 8'b0000_0010);
    chk("err1_rdata", r_rdata, 32'h0);
    chk("err1_err_at_ready", r_err, 1);
    chk("err1_err_cnt", r_err_cnt, 1);

    // Decode miss: index 9 is beyond the 8 slaves.
    xfer(32'h0000_9000, 32'h0, 4'h0, 0, 9, 32'h0, 0, 0, 50);
    chk("miss_done", r_done, 1);
    chk("miss_lat", r_lat, 1);
    chk("miss_psel", r_psel_or, 0);
    chk("miss_rdata", r_rdata, 32'h0);
    chk("miss_err", r_err, 1);

    // Highest slave, one wait state, other slaves ready but not selected.
    xfer(32'h0000_7FFC, 32'h0, 4'h0, 1, 7, 32'hCAFE_F00D, 0, 1, 50);
    chk("rd7_done", r_done, 1);
    chk("rd7_lat", r_lat, 4);
    chk("rd7_psel", r_psel_or, 8'b1000_0000);
    chk("rd7_paddr", r_paddr, 12'hFFC);
    chk("rd7_rdata", r_rdata, 32'hCAFE_F00D);
    chk("rd7_err", r_err_cnt, 0);

    // Slave 3 never answers; other slaves hold pready high.
`ifdef APB_TIMEOUT_EN
    xfer(32'h0000_3000, 32'h0, 4'h0, 100000, 3, 32'h1111_1111, 0, 1, 50);
    chk("to_done", r_done, 1);
    chk("to_lat", r_lat, 6);
    chk("to_sel_cyc", r_sel_cyc, 5);
    chk("to_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("to_err", r_err, 1);
`else
    xfer(32'h0000_3000, 32'h0, 4'h0, 100000, 3, 32'h1111_1111, 0, 1, 1000);
    chk("hang_no_ready", r_done, 0);
    chk("hang_state", dbg_state, 2);
    chk("hang_psel", r_psel_or, 8'b0000_1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("hang_rst_state", dbg_state, 0);
`endif

    // Reset asserted during ACCESS aborts without a response.
    @(negedge clk);
    mmap_valid = 1'b1; mmap_addr = 32'h0000_5000; mmap_wstrb = 4'h0;
    pready = '0;
    repeat (2) @(negedge clk);
    chk("rstacc_in_access", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc_psel", psel, 0);
    chk("rstacc_penable", penable, 0);
    chk("rstacc_ready", mmap_ready, 0);
    rst = 1'b0;
    mmap_valid = 1'b0;
    @(negedge clk);
    xfer(32'h0000_4100, 32'h0, 4'h0, 0, 4, 32'h600D_CAFE, 0, 0, 50);
    chk("post_rst_done", r_done, 1);
    chk("post_rst_lat", r_lat, 3);
    chk("post_rst_psel", r_psel_or, 8'b0001_0000);
    chk("post_rst_rdata", r_rdata, 32'h600D_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
